// File: rtl/pixel_pkg.sv
// Shared pixel definitions for the processing chain. data_processing_block and
// pixel_word_packer both import this so they agree on the pixel width.
//   PIX_W          bits per pixel
//   LANES_DEFAULT  default pixels per packed output word
//   MAX_LANES      widest word supported by keep_from_cnt
//   pixel_t        one pixel
//   keep_from_cnt  contiguous lane mask covering lanes 0..cnt
package pixel_pkg;

    localparam int PIX_W         = 8;
    localparam int LANES_DEFAULT = 4;
    localparam int MAX_LANES     = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    // Equivalent to (1 << (cnt + 1)) - 1, truncated to MAX_LANES bits.
    function automatic logic [MAX_LANES-1:0] keep_from_cnt(input int unsigned cnt);
        logic [MAX_LANES-1:0] keep;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            keep[i] = (i <= cnt);
        end
        return keep;
    endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// Stream bundle around pixel_word_packer.
//   Pixel side : valid_in, ready_in, data_in[PIX_W], last_in
//   Word side  : valid_out, ready_out, data_out[PIX_W*LANES], keep_out[LANES], last_out
// Modports:
//   slave  - the packer itself (sinks pixels, sources words)
//   master - the environment around it (sources pixels, sinks words)
interface pixel_word_packer_if #(
    parameter int LANES = pixel_pkg::LANES_DEFAULT
) ();
    import pixel_pkg::*;

    logic                   valid_in;
    logic                   ready_in;
    pixel_t                 data_in;
    logic                   last_in;
    logic                   valid_out;
    logic                   ready_out;
    logic [PIX_W*LANES-1:0] data_out;
    logic [LANES-1:0]       keep_out;
    logic                   last_out;

    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, keep_out, last_out
    );

    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, keep_out, last_out
    );

endinterface

// File: rtl/pix_out_reg.sv
// Single-entry valid/ready holding register for an arbitrary payload.
// Loads whenever it is empty or its current entry is leaving in the same
// cycle, so a continuously ready consumer sees no bubbles.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     load side handshake
//   in_data[W]            payload to load
//   out_valid/out_ready   drain side handshake
//   out_data[W]           held payload (stable while out_valid && !out_ready)
module pix_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // A load in the drain cycle overrides the drop above.
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Packs a pixel stream into LANES-pixel words. A word closes when lane
// LANES-1 is filled or when a pixel carries last_in; partial words are
// emitted with a contiguous keep mask. Output latency is one cycle from the
// completing pixel.
//   clk, rst   clock, synchronous active-high reset
//   bus        pixel_word_packer_if.slave (pixel input + word output streams)
//   line_cnt   [15:0] count of words handed off with last_out=1
//              (only when PIXEL_PACKER_LINE_CNT_EN is defined)
// LANES must match the interface instance parameter; legal range 2..8.
module pixel_word_packer #(
    parameter int LANES = pixel_pkg::LANES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    pixel_word_packer_if.slave    bus
`ifdef PIXEL_PACKER_LINE_CNT_EN
    ,
    output logic [15:0]           line_cnt
`endif
);
    import pixel_pkg::*;

    localparam int CNT_W  = $clog2(LANES);
    localparam int WORD_W = PIX_W * LANES;
    localparam int PAY_W  = WORD_W + LANES + 1;

    typedef logic [LANES-1:0] keep_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [LANES-1:0][PIX_W-1:0] acc_q, acc_d, merged;
    cnt_t                        cnt_q, cnt_d;
    logic                        reg_ready;
    logic                        accept;
    logic                        complete;
    keep_t                       keep_new;
    logic [PAY_W-1:0]            pay_in, pay_out;
    logic                        out_valid;

    // Accumulator with the incoming pixel dropped into lane cnt. Lanes above
    // cnt are already zero because the accumulator clears on every completion.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
        assign merged[gi] = (cnt_q == cnt_t'(gi)) ? bus.data_in : acc_q[gi];
    end

    assign bus.ready_in = !rst && reg_ready;
    assign accept       = bus.valid_in && bus.ready_in;
    assign complete     = accept && (bus.last_in || (cnt_q == cnt_t'(LANES - 1)));
    assign keep_new     = keep_t'(keep_from_cnt(32'(cnt_q)));
    assign pay_in       = {merged, keep_new, bus.last_in};

    // complete implies reg_ready, so a completing word always loads.
    pix_out_reg #(
        .W (PAY_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (complete),
        .in_ready  (reg_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (bus.ready_out),
        .out_data  (pay_out)
    );

    assign bus.valid_out = out_valid;
    assign {bus.data_out, bus.keep_out, bus.last_out} = pay_out;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (complete) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = merged;
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef PIXEL_PACKER_LINE_CNT_EN
    logic [15:0] line_cnt_q, line_cnt_d;

    always_comb begin
        line_cnt_d = line_cnt_q;
        if (out_valid && bus.ready_out && bus.last_out) begin
            line_cnt_d = line_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_q <= '0;
        end else begin
            line_cnt_q <= line_cnt_d;
        end
    end

    assign line_cnt = line_cnt_q;
`endif

endmodule
